// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int unsigned S_U_MAX     = 9;
  localparam int unsigned S_T_MAX     = 5;
  localparam int unsigned M_U_MAX     = 9;
  localparam int unsigned M_T_MAX     = 5;
  localparam int unsigned H_U_MAX     = 9;
  localparam int unsigned H_T_MAX     = 2;
  localparam int unsigned HOUR_LIMIT  = 23;
  localparam int unsigned ALARM_CNT_W = 8;

  // A preset is accepted only if every digit is in range and hours do not exceed 23.
  function automatic logic preset_ok(
    input logic [3:0] su, input logic [2:0] st,
    input logic [3:0] mu, input logic [2:0] mt,
    input logic [3:0] hu, input logic [1:0] ht
  );
    logic [5:0] hours;
    hours = 6'(ht) * 6'd10 + 6'(hu);
    return (su <= 4'(S_U_MAX)) && (st <= 3'(S_T_MAX)) &&
           (mu <= 4'(M_U_MAX)) && (mt <= 3'(M_T_MAX)) &&
           (hu <= 4'(H_U_MAX)) && (ht <= 2'(H_T_MAX)) &&
           (hours <= 6'(HOUR_LIMIT));
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One mod-(MAX+1) BCD down-counting digit; borrow_c fires when a decrement wraps 0 -> MAX.
module bcd_down_digit #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         borrow_c
);

  assign borrow_c = dec && (q == '0);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (load)  q <= ld_val;
    else if (dec)   q <= (q == '0) ? W'(MAX) : q - W'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with pause/resume, load validation and a timed alarm.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] ld_s_u,
  input  logic [2:0] ld_s_t,
  input  logic [3:0] ld_m_u,
  input  logic [2:0] ld_m_t,
  input  logic [3:0] ld_h_u,
  input  logic [1:0] ld_h_t,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] s_u,
  output logic [2:0] s_t,
  output logic [3:0] m_u,
  output logic [2:0] m_t,
  output logic [3:0] h_u,
  output logic [1:0] h_t,
  output logic       running,
  output logic       expired,
  output logic       alarm,
  output logic       load_err
);

  state_t                 state;
  logic [ALARM_CNT_W-1:0] alarm_cnt;
  logic load_ok, count_zero, last_sec, tick;
  logic b_su, b_st, b_mu, b_mt, b_hu, b_ht;
  logic unused_borrow;

  assign load_ok    = preset_ok(ld_s_u, ld_s_t, ld_m_u, ld_m_t, ld_h_u, ld_h_t);
  assign count_zero = (s_u == '0) && (s_t == '0) && (m_u == '0) &&
                      (m_t == '0) && (h_u == '0) && (h_t == '0);
  assign last_sec   = (s_u == 4'd1) && (s_t == '0) && (m_u == '0) &&
                      (m_t == '0) && (h_u == '0) && (h_t == '0);
  // Higher-priority strobes (load, pause) swallow the tick for this cycle.
  assign tick       = (state == ST_RUN) && en && !load && !pause && !count_zero;
  assign unused_borrow = b_ht;

  bcd_down_digit #(.W(4), .MAX(S_U_MAX)) u_s_u (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_s_u),
    .dec(tick), .q(s_u), .borrow_c(b_su));
  bcd_down_digit #(.W(3), .MAX(S_T_MAX)) u_s_t (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_s_t),
    .dec(b_su), .q(s_t), .borrow_c(b_st));
  bcd_down_digit #(.W(4), .MAX(M_U_MAX)) u_m_u (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_m_u),
    .dec(b_st), .q(m_u), .borrow_c(b_mu));
  bcd_down_digit #(.W(3), .MAX(M_T_MAX)) u_m_t (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_m_t),
    .dec(b_mu), .q(m_t), .borrow_c(b_mt));
  bcd_down_digit #(.W(4), .MAX(H_U_MAX)) u_h_u (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_h_u),
    .dec(b_mt), .q(h_u), .borrow_c(b_hu));
  bcd_down_digit #(.W(2), .MAX(H_T_MAX)) u_h_t (
    .clk(clk), .reset(reset), .load(load && load_ok), .ld_val(ld_h_t),
    .dec(b_hu), .q(h_t), .borrow_c(b_ht));

  // Control FSM; status outputs are updated alongside the state they reflect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
      load_err  <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      load_err <= load && !load_ok;
      if (load) begin
        if (load_ok) begin
          state     <= ST_IDLE;
          running   <= 1'b0;
          expired   <= 1'b0;
          alarm     <= 1'b0;
          alarm_cnt <= '0;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (pause) begin
              state   <= ST_PAUSED;
              running <= 1'b0;
            end else if (tick && last_sec) begin
              state     <= ST_EXPIRED;
              running   <= 1'b0;
              expired   <= 1'b1;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end
          end
          ST_IDLE, ST_PAUSED: begin
            if (start && !count_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_EXPIRED: begin
            if (start) begin
              state     <= ST_IDLE;
              expired   <= 1'b0;
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else if (en && alarm) begin
              if (alarm_cnt == ALARM_CNT_W'(ALARM_TICKS - 1)) alarm <= 1'b0;
              alarm_cnt <= alarm_cnt + ALARM_CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, en, load, start, pause;
  logic [3:0] ld_s_u, ld_m_u, ld_h_u;
  logic [2:0] ld_s_t, ld_m_t;
  logic [1:0] ld_h_t;
  logic [3:0] s_u, m_u, h_u;
  logic [2:0] s_t, m_t;
  logic [1:0] h_t;
  logic       running, expired, alarm, load_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  countdown_timer #(.ALARM_TICKS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .ld_s_u(ld_s_u), .ld_s_t(ld_s_t), .ld_m_u(ld_m_u),
    .ld_m_t(ld_m_t), .ld_h_u(ld_h_u), .ld_h_t(ld_h_t),
    .start(start), .pause(pause),
    .s_u(s_u), .s_t(s_t), .m_u(m_u), .m_t(m_t), .h_u(h_u), .h_t(h_t),
    .running(running), .expired(expired), .alarm(alarm), .load_err(load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count as hex-looking HHMMSS so expected values read naturally, e.g. 32'h005959.
  function automatic logic [31:0] cnt();
    return {8'h0, 2'b0, h_t, h_u, 1'b0, m_t, m_u, 1'b0, s_t, s_u};
  endfunction

  function automatic logic [31:0] stat();
    return {29'h0, running, expired, alarm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int ht, input int hu, input int mt, input int mu,
                         input int st, input int su);
    ld_h_t = 2'(ht); ld_h_u = 4'(hu); ld_m_t = 3'(mt);
    ld_m_u = 4'(mu); ld_s_t = 3'(st); ld_s_u = 4'(su);
    load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic do_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic do_en();    en    = 1'b1; step(); en    = 1'b0; endtask

  initial begin
    reset = 1'b1; en = 0; load = 0; start = 0; pause = 0;
    ld_s_u = 0; ld_s_t = 0; ld_m_u = 0; ld_m_t = 0; ld_h_u = 0; ld_h_t = 0;
    step(); step();
    reset = 1'b0;
    check("reset_count", cnt(), 32'h000000);
    check("reset_status", stat(), 32'h0);
    check("reset_load_err", 32'(load_err), 32'h0);

    do_start();
    check("start_zero_idle", stat(), 32'h0);

    // 00:00:03 countdown to expiry, then alarm window of 10 ticks
    do_load(0,0,0,0,0,3);
    check("load3_count", cnt(), 32'h000003);
    do_start();
    check("load3_running", stat(), 32'h4);
    do_en(); check("dec_02", cnt(), 32'h000002);
    do_en(); check("dec_01", cnt(), 32'h000001);
    check("not_expired_yet", stat(), 32'h4);
    do_en(); check("dec_00", cnt(), 32'h000000);
    check("expired_alarm", stat(), 32'h3);
    for (int i = 0; i < 9; i++) do_en();
    check("alarm_after_9", stat(), 32'h3);
    do_en();
    check("alarm_off_10", stat(), 32'h2);
    do_en(); do_en();
    check("no_wrap", cnt(), 32'h000000);

    // hour borrow chains
    do_load(0,1,0,0,0,0); do_start(); do_en();
    check("borrow_1h", cnt(), 32'h005959);
    check("borrow_1h_run", stat(), 32'h4);

    // invalid loads leave count and state alone
    do_load(0,0,0,0,6,0);
    check("bad_st_err", 32'(load_err), 32'h1);
    check("bad_st_count", cnt(), 32'h005959);
    check("bad_st_state", stat(), 32'h4);
    step();
    check("bad_st_err_pulse", 32'(load_err), 32'h0);
    do_load(2,4,0,0,0,0);
    check("bad_24h_err", 32'(load_err), 32'h1);
    check("bad_24h_count", cnt(), 32'h005959);
    do_load(2,3,5,9,5,9);
    check("ok_23h_err", 32'(load_err), 32'h0);
    check("ok_23h_count", cnt(), 32'h235959);
    check("ok_23h_idle", stat(), 32'h0);
    do_en();
    check("idle_no_dec", cnt(), 32'h235959);

    do_load(2,0,0,0,0,0); do_start(); do_en();
    check("borrow_20h", cnt(), 32'h195959);
    do_load(1,0,0,0,0,0); do_start(); do_en();
    check("borrow_10h", cnt(), 32'h095959);

    // pause wins over en in the same cycle
    do_load(0,0,1,0,0,0); do_start();
    pause = 1'b1; en = 1'b1; step(); pause = 1'b0; en = 1'b0;
    check("pause_state", stat(), 32'h0);
    check("pause_count", cnt(), 32'h001000);
    for (int i = 0; i < 5; i++) do_en();
    check("paused_hold", cnt(), 32'h001000);
    do_start();
    check("resume_run", stat(), 32'h4);
    do_en();
    check("resume_dec", cnt(), 32'h000959);

    // reset mid-run
    do_load(0,0,0,0,0,5); do_start(); do_en();
    check("pre_reset_count", cnt(), 32'h000004);
    reset = 1'b1; step(); reset = 1'b0;
    check("midrun_reset_count", cnt(), 32'h000000);
    check("midrun_reset_status", stat(), 32'h0);
    do_start();
    check("zero_start_ignored", stat(), 32'h0);

    // start acknowledges expiry
    do_load(0,0,0,0,0,1); do_start(); do_en();
    check("exp1_status", stat(), 32'h3);
    do_start();
    check("ack_status", stat(), 32'h0);
    check("ack_count", cnt(), 32'h000000);

    // reset mid-alarm: no residual alarm
    do_load(0,0,0,0,0,1); do_start(); do_en();
    check("exp2_status", stat(), 32'h3);
    reset = 1'b1; step(); reset = 1'b0;
    do_en(); do_en();
    check("midalarm_reset", stat(), 32'h0);

    // load clears alarm from EXPIRED
    do_load(0,0,0,0,0,1); do_start(); do_en();
    do_load(0,0,0,0,4,2);
    check("load_from_exp_status", stat(), 32'h0);
    check("load_from_exp_count", cnt(), 32'h000042);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 10: number of en ticks for which alarm stays high after expiry.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  one-second tick enable; one-cycle pulse per second.
REQ-005 SHALL have port load  input  1  load preset digits (one-cycle strobe).
REQ-006 SHALL have ports ld_s_u 4, ld_s_t 3, ld_m_u 4, ld_m_t 3, ld_h_u 4, ld_h_t 2, all input: preset BCD digits (sec units/tens, min units/tens, hour units/tens).
REQ-007 SHALL have port start  input  1  start/resume/acknowledge strobe.
REQ-008 SHALL have port pause  input  1  pause strobe.
REQ-009 SHALL have ports s_u 4, s_t 3, m_u 4, m_t 3, h_u 4, h_t 2, all output: current BCD count, same digit widths as the up-counter.
REQ-010 SHALL have port running  output  1  high in RUN state.
REQ-011 SHALL have port expired  output  1  high in EXPIRED state.
REQ-012 SHALL have port alarm  output  1  high for ALARM_TICKS en ticks after expiry.
REQ-013 SHALL have port load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, EXPIRED.
REQ-015 Strobe priority SHALL be reset > load > pause > start > en tick when asserted in the same cycle.
REQ-016 A valid load SHALL do two things on the next edge in any state: copy the ld_* digits into the count and enter IDLE; alarm SHALL clear.
REQ-017 A load SHALL be valid only if s_u<=9, s_t<=5, m_u<=9, m_t<=5, h_u<=9, h_t<=2 and hours<=23.
REQ-018 An invalid load SHALL leave count and state unchanged and pulse load_err for exactly one cycle.
REQ-019 start in IDLE or PAUSED SHALL enter RUN when the count is nonzero, and SHALL have no effect when the count is 00:00:00.
REQ-020 start in EXPIRED SHALL enter IDLE and clear alarm; the count remains 00:00:00.
REQ-021 pause in RUN SHALL enter PAUSED; pause in any other state SHALL be ignored.
REQ-022 In RUN, each cycle with en=1 SHALL decrement the count by one second on that edge (latency 1 cycle).
REQ-023 Decrement borrow rules, with a lower digit borrowing only when it is 0:
- s_u 0->9 borrows from s_t; s_t 0->5 borrows from m_u.
- m_u 0->9 borrows from m_t; m_t 0->5 borrows from h_u.
- h_u 0->9 borrows from h_t.
REQ-024 When a decrement produces 00:00:00, the same edge SHALL enter EXPIRED and set alarm=1.
REQ-025 The count SHALL never wrap below 00:00:00, and SHALL NOT decrement in IDLE, PAUSED or EXPIRED.
REQ-026 In EXPIRED, alarm SHALL fall after ALARM_TICKS further en pulses; expired SHALL remain high until load or start.
REQ-027 en SHALL be ignored outside RUN, except for the alarm tick counting in EXPIRED.
REQ-028 In RUN, a cycle with pause and en both high SHALL enter PAUSED without decrementing.

Reset
REQ-029 reset SHALL force, on the next clk edge: state IDLE, all digits 0, running=0, expired=0, alarm=0, load_err=0, alarm tick counter 0.
REQ-030 reset asserted mid-run or mid-alarm SHALL abort immediately with no residual alarm pulse.

Structure
REQ-031 Package timer_pkg SHALL hold the state encoding, the digit maxima (9, 5, 9, 5, 9, 2), the hour limit 23 and the alarm counter width.
REQ-032 SHALL instantiate sub-module bcd_down_digit six times: a parameterized mod-N down digit with load, dec-enable and borrow-out.
REQ-033 Digit instances SHALL chain borrow-out to the next digit's dec-enable, mirroring the up-counter's carry chain.

Verification
REQ-034 Load 00:00:03, start, 3 en pulses -> count 02, 01, 00; expired=1 and alarm=1 on the 3rd pulse edge; alarm low after 10 more en pulses.
REQ-035 Load 01:00:00, start, 1 en pulse -> count 00:59:59, running=1.
REQ-036 Load ld_s_t=6 -> load_err one-cycle pulse, count and state unchanged; load hours 24 -> load_err.
REQ-037 RUN at 00:10:00, pause and en in the same cycle -> PAUSED, count 00:10:00; 5 en pulses -> unchanged; start, 1 en pulse -> 00:09:59.
REQ-038 RUN at 00:00:05, assert reset for one cycle -> all outputs 0, state IDLE; start with zero count -> stays IDLE.
REQ-039 EXPIRED with alarm high, then start -> IDLE, alarm=0, expired=0.
